fadd_fsub_core: RTL and testbench

- IEEE-754 binary32 adder/subtractor for the RISC-V F-extension FADD.S/FSUB.S datapath.
- Combinational align/add/normalize/round datapath followed by one output register.
- Sits in the FPU execute stage and is selected by the FPU decoder through `En` and `Funct`.

---
 rtl/fp_pkg.sv | 34 +++
 rtl/fadd_fsub_core_if.sv | 13 +
 rtl/fp_lzc24.sv | 15 +
 rtl/fadd_fsub_core.sv | 111 +++++++++++
 tb/tb_fadd_fsub_core.sv | 128 ++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared binary32 definitions for the FPU: field widths, special encodings
// and an operand classifier.
package fp_pkg;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXP_BIAS = 127;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF   = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF   = 32'hFF80_0000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] expn;
        logic [MAN_W-1:0] frac;
    } fp_t;

    typedef enum logic [1:0] {
        FP_ZERO   = 2'd0,
        FP_NORMAL = 2'd1,
        FP_INF    = 2'd2,
        FP_NAN    = 2'd3
    } fp_class_e;

    // Subnormals classify as zero: this FPU flushes them on input.
    function automatic fp_class_e fp_classify(input fp_t x);
        if (x.expn == '0) begin
            return FP_ZERO;
        end else if (x.expn == '1) begin
            return (x.frac == '0) ? FP_INF : FP_NAN;
        end
        return FP_NORMAL;
    endfunction
endpackage

// File: rtl/fadd_fsub_core_if.sv
// Operand/result bundle between the FPU decoder and the add/sub unit.
interface fadd_fsub_core_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] frs1;
    logic [XLEN-1:0] frs2;
    logic            En;
    logic            Funct;
    logic [XLEN-1:0] frd;

    modport master (output frs1, frs2, En, Funct, input frd);
    modport slave  (input frs1, frs2, En, Funct, output frd);
endinterface

// File: rtl/fp_lzc24.sv
// 24-bit leading-zero counter; an all-zero input reports 24.
module fp_lzc24 (
    input  logic [23:0] value,
    output logic [4:0]  count
);
    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        count = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (value[i]) begin
                count = 5'(23 - i);
            end
        end
    end
endmodule

// File: rtl/fadd_fsub_core.sv
// binary32 FADD.S/FSUB.S: combinational align/add/normalize/round with a
// single registered result, RNE rounding and flush-to-zero on both ends.
module fadd_fsub_core
    import fp_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input logic              clk,
    input logic              rst_n,
    fadd_fsub_core_if.slave  bus
);
    fp_t             op_a, op_b, op_big, op_sml;
    fp_class_e       cls_a, cls_b;
    logic            swap, eff_sub, round_up;
    logic [7:0]      exp_diff;
    logic [23:0]     man_big, man_sml;
    logic [49:0]     align_wide;
    logic [26:0]     big_ext, sml_ext, diff, diff_norm, mant_pre;
    logic [27:0]     sum;
    logic [4:0]      lz;
    logic [9:0]      exp_pre, exp_rnd;
    logic [24:0]     man_rnd;
    logic [22:0]     frac_out;
    logic [31:0]     res_c;
    logic [XLEN-1:0] frd_q;

    assign op_a  = bus.frs1;
    assign op_b  = {bus.frs2[31] ^ bus.Funct, bus.frs2[30:0]};
    assign cls_a = fp_classify(op_a);
    assign cls_b = fp_classify(op_b);

    // Order by magnitude so the subtraction below never goes negative.
    assign swap    = {op_b.expn, op_b.frac} > {op_a.expn, op_a.frac};
    assign op_big  = swap ? op_b : op_a;
    assign op_sml  = swap ? op_a : op_b;
    assign eff_sub = op_big.sign ^ op_sml.sign;

    assign man_big    = {1'b1, op_big.frac};
    assign man_sml    = {1'b1, op_sml.frac};
    assign exp_diff   = op_big.expn - op_sml.expn;
    assign align_wide = {man_sml, 26'd0} >> exp_diff;
    assign big_ext    = {man_big, 3'b000};
    assign sml_ext    = (exp_diff >= 8'd26) ? 27'd1
                                            : {align_wide[49:24], |align_wide[23:0]};

    assign sum  = {1'b0, big_ext} + {1'b0, sml_ext};
    assign diff = big_ext - sml_ext;

    fp_lzc24 u_lzc (
        .value (diff[26:3]),
        .count (lz)
    );

    // A count of 24 still lands the lone guard bit on the MSB.
    assign diff_norm = diff << lz;

    always_comb begin
        mant_pre = sum[26:0];
        exp_pre  = 10'(op_big.expn);
        if (eff_sub) begin
            mant_pre = diff_norm;
            exp_pre  = 10'(op_big.expn) - 10'(lz);
        end else if (sum[27]) begin
            mant_pre = {sum[27:2], |sum[1:0]};
            exp_pre  = 10'(op_big.expn) + 10'd1;
        end
    end

    assign round_up = mant_pre[2] & (mant_pre[1] | mant_pre[0] | mant_pre[3]);
    assign man_rnd  = {1'b0, mant_pre[26:3]} + 25'(round_up);
    assign exp_rnd  = exp_pre + 10'(man_rnd[24]);
    assign frac_out = man_rnd[24] ? man_rnd[23:1] : man_rnd[22:0];

    // Specials take priority over the arithmetic path.
    always_comb begin
        res_c = '0;
        if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            res_c = CANON_NAN;
        end else if (cls_a == FP_INF && cls_b == FP_INF) begin
            res_c = (op_a.sign != op_b.sign) ? CANON_NAN : op_a;
        end else if (cls_a == FP_INF) begin
            res_c = op_a;
        end else if (cls_b == FP_INF) begin
            res_c = op_b;
        end else if (cls_a == FP_ZERO && cls_b == FP_ZERO) begin
            res_c = {op_a.sign & op_b.sign, 31'd0};
        end else if (cls_a == FP_ZERO) begin
            res_c = op_b;
        end else if (cls_b == FP_ZERO) begin
            res_c = op_a;
        end else if (eff_sub && diff == '0) begin
            res_c = '0;
        end else if (exp_pre[9] || exp_pre == '0) begin
            res_c = {op_big.sign, 31'd0};
        end else if (exp_rnd >= 10'd255) begin
            res_c = op_big.sign ? NEG_INF : POS_INF;
        end else begin
            res_c = {op_big.sign, exp_rnd[7:0], frac_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frd_q <= '0;
        end else if (bus.En) begin
            frd_q <= res_c;
        end
    end

    assign bus.frd = frd_q;
endmodule

// File: tb/tb_fadd_fsub_core.sv
// Scoreboard bench for fadd_fsub_core: expected results are queued as each
// operation is driven and retired one rising edge later.
module tb_fadd_fsub_core;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [XLEN-1:0] exp_q[$];

    fadd_fsub_core_if #(.XLEN(XLEN)) bus ();

    fadd_fsub_core #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic retire(input string tag);
        logic [31:0] want;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            want = exp_q.pop_front();
            check_eq(tag, bus.frd, want);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic f, input logic [31:0] r);
        @(negedge clk);
        bus.frs1  = a;
        bus.frs2  = b;
        bus.Funct = f;
        bus.En    = 1'b1;
        exp_q.push_back(r);
        @(posedge clk);
        #1;
        retire(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.En    = 1'b1;
        bus.Funct = 1'b0;
        bus.frs1  = 32'h3F80_0000;
        bus.frs2  = 32'h3F80_0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset", bus.frd, 32'h0);

        @(negedge clk);
        bus.En = 1'b0;
        rst_n  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("hold_after_reset", bus.frd, 32'h0);

        run_op("add_zero",      32'h4020_0000, 32'h0000_0000, 1'b0, 32'h4020_0000);
        run_op("add_mixed",     32'hC020_0000, 32'h3FA0_0000, 1'b0, 32'hBFA0_0000);
        run_op("sub_zero",      32'h4020_0000, 32'h0000_0000, 1'b1, 32'h4020_0000);
        run_op("sub_same_sign", 32'hC020_0000, 32'h3FA0_0000, 1'b1, 32'hC070_0000);
        run_op("sub_neg_neg",   32'hC020_0000, 32'hBFA0_0000, 1'b1, 32'hBFA0_0000);
        run_op("add_one_one",   32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);
        run_op("sub_half",      32'h3F80_0000, 32'h3F00_0000, 1'b1, 32'h3F00_0000);
        run_op("rnd_tie_even",  32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
        run_op("rnd_up",        32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001);
        run_op("rnd_carry",     32'h3FFF_FFFF, 32'h3380_0000, 1'b0, 32'h4000_0000);
        run_op("add_carry",     32'h3FFF_FFFF, 32'h3400_0000, 1'b0, 32'h4000_0000);
        run_op("far_shift",     32'h3F80_0000, 32'h3200_0000, 1'b0, 32'h3F80_0000);
        run_op("overflow",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
        run_op("cancel",        32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000);
        run_op("cancel_neg",    32'hBF80_0000, 32'h3F80_0000, 1'b0, 32'h0000_0000);
        run_op("inf_minus_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
        run_op("nan_in",        32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000);
        run_op("inf_plus_fin",  32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000);
        run_op("fin_minus_inf", 32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000);
        run_op("negz_negz",     32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
        run_op("negz_sub_posz", 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h8000_0000);
        run_op("posz_negz",     32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000);
        run_op("subnorm_in",    32'h0040_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000);
        run_op("subnorm_b",     32'h3F80_0000, 32'h0000_0001, 1'b0, 32'h3F80_0000);
        run_op("uflow_pos",     32'h00C0_0000, 32'h0080_0000, 1'b1, 32'h0000_0000);
        run_op("uflow_neg",     32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000);

        run_op("gate_setup",    32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.En    = 1'b0;
            bus.frs1  = $urandom;
            bus.frs2  = $urandom;
            bus.Funct = 1'($urandom_range(1));
            @(posedge clk);
            #1;
            check_eq($sformatf("gate_hold%0d", i), bus.frd, 32'h4000_0000);
        end

        @(negedge clk);
        bus.En   = 1'b1;
        bus.frs1 = 32'h4020_0000;
        bus.frs2 = 32'h3F80_0000;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset", bus.frd, 32'h0);
        @(posedge clk);
        #1;
        check_eq("reset_discard", bus.frd, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        bus.En = 1'b0;

        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
